bus_flag_monitor: RTL and testbench
===================================

BUS_FLAG_MONITOR -- requirements
Module: bus_flag_monitor

Interface
REQ-001 Parameter WIDTH, default 16, width of the shared bus and of each driver data word.
REQ-002 Parameter NUM_DRV, default 4, number of tri-state bus drivers; legal range 2..16.
REQ-003 Parameter CNT_W, default 8, width of the saturating error counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 drv_ena  input  NUM_DRV  per-driver bus enable; bit i enables driver i.
REQ-007 drv_data  input  NUM_DRV*WIDTH  driver i's output word in bits [i*WIDTH +: WIDTH].
REQ-008 bus  input  WIDTH  resolved bus value.
REQ-009 flag_we  input  1  condition-code write enable.
REQ-010 n, z, p  input  1 each  condition-code flag register outputs under test.
REQ-011 clear  input  1  clears sticky errors, counter and capture without a full reset.
REQ-012 err_multi  output  1  sticky: more than one drv_ena bit was high.
REQ-013 err_bus  output  1  sticky: bus differed from the single enabled driver's data.
REQ-014 err_flag  output  1  sticky: N/Z/P differed from the value expected after a flag_we.
REQ-015 err_nzp  output  1  sticky: more than one of n, z, p was high.
REQ-016 err_count  output  CNT_W  saturating count of cycles with at least one error.
REQ-017 first_valid  output  1  a first-error record is held.
REQ-018 first_code  output  3  code of the first error: 1 multi, 2 bus, 3 flag, 4 nzp.
REQ-019 first_drv  output  4  enabled-driver index for code 2, otherwise 0.
REQ-020 first_data  output  WIDTH  bus value in the cycle of the first error.

Function
REQ-021 Multi-driver check: the block shall flag an error in any cycle where popcount(drv_ena) > 1.
REQ-022 Bus check: when exactly one bit i of drv_ena is high, the block shall flag an error if bus != drv_data[i].
REQ-023 Bus check, boundary: when no drv_ena bit is high, the block shall not check the bus.
REQ-024 Flag expectation stage: when flag_we is high, the block shall register an expectation at the clock edge: exp_n = bus[WIDTH-1]; exp_z = (bus == 0); exp_p = !bus[WIDTH-1] && bus != 0; exp_valid = 1.
REQ-025 When flag_we is low, the block shall clear exp_valid at the clock edge.
REQ-026 Flag check: in the cycle after a flag_we, with exp_valid = 1, the block shall flag an error if {n,z,p} != {exp_n,exp_z,exp_p]; latency is exactly one cycle.
REQ-027 Back-to-back flag_we: each cycle's expectation shall replace the previous one, and every cycle shall be checked independently.
REQ-028 NZP check: the block shall flag an error in any cycle where n+z+p > 1.
REQ-029 Sticky flags: each err_* shall set on the clock edge after its error is detected and shall hold until rst or clear.
REQ-030 Counter: err_count shall increment by 1 per cycle in which any error is detected.
REQ-031 Counter saturation: err_count shall saturate at 2^CNT_W-1 and shall not wrap.
REQ-032 Capture: when first_valid = 0 and an error is detected, the block shall load first_code, first_drv and first_data and set first_valid.
REQ-033 Capture priority: simultaneous errors shall record the lowest code.
REQ-034 Capture hold: once first_valid = 1, the capture registers shall not change until rst or clear.
REQ-035 clear: a cycle with clear high shall zero all err_*, err_count and first_* and clear exp_valid, and shall discard any error detected in that same cycle.
REQ-036 All checks are purely observational; the block shall drive no bus.

Reset
REQ-037 While rst is high, the block shall suppress all checks.
REQ-038 On a clock edge with rst high, the block shall force err_multi, err_bus, err_flag, err_nzp, err_count, first_valid, first_code, first_drv, first_data and exp_valid to 0.
REQ-039 No flag check shall occur in the first cycle after rst deasserts, even if flag_we was high during reset.
REQ-040 Reset asserted mid-operation shall discard any pending flag expectation.

Verification
REQ-041 drv_ena=4'b0100, drv_data[2]=16'h1234, bus=16'h1234 for 10 cycles -> all err_* = 0, err_count = 0.
REQ-042 drv_ena=4'b0101 for one cycle -> next cycle err_multi=1, err_count=1, first_code=1, first_data=bus.
REQ-043 bus=16'h8000 with flag_we=1, then n,z,p=0,1,0 next cycle -> err_flag=1, first_code=3; repeat with n,z,p=1,0,0 -> no error.
REQ-044 Same cycle: drv_ena=4'b0010 with bus != drv_data[1], and n=z=1 -> err_bus=1, err_nzp=1, err_count +1, first_code=2, first_drv=1.
REQ-045 CNT_W=2 with errors injected for 6 cycles -> err_count stops at 3; clear pulse -> all outputs 0 next cycle.
REQ-046 flag_we=1 with rst=1 in the same cycle, rst deasserted next cycle with wrong flags -> no err_flag.

Source files
------------

// File: rtl/bus_flag_monitor.sv
// bus_flag_monitor
//   Passive checker for a shared tri-state bus and an N/Z/P condition-code
//   register. It never drives the bus. Each cycle it looks for four kinds of
//   error:
//     code 1  more than one driver enabled
//     code 2  the bus differs from the data of the single enabled driver
//     code 3  N/Z/P differs from the value the previous cycle's flag_we
//             predicted from the bus
//     code 4  more than one of N/Z/P high
//   Each error kind has a sticky flag. A saturating counter counts the cycles
//   that contain at least one error. The first error seen is captured, with
//   the lowest code winning on a tie.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   drv_ena         per-driver enable, bit i enables driver i
//   drv_data        driver i word at [i*WIDTH +: WIDTH]
//   bus             resolved bus value
//   flag_we         condition-code write enable
//   n, z, p         condition-code flags under test
//   clear           zeroes sticky errors, counter, capture and expectation
//   err_multi/err_bus/err_flag/err_nzp   sticky error flags
//   err_count       saturating count of error cycles
//   first_valid/first_code/first_drv/first_data   first-error record
module bus_flag_monitor #(
  parameter int WIDTH   = 16,
  parameter int NUM_DRV = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DRV-1:0]       drv_ena,
  input  logic [NUM_DRV*WIDTH-1:0] drv_data,
  input  logic [WIDTH-1:0]         bus,
  input  logic                     flag_we,
  input  logic                     n,
  input  logic                     z,
  input  logic                     p,
  input  logic                     clear,
  output logic                     err_multi,
  output logic                     err_bus,
  output logic                     err_flag,
  output logic                     err_nzp,
  output logic [CNT_W-1:0]         err_count,
  output logic                     first_valid,
  output logic [2:0]               first_code,
  output logic [3:0]               first_drv,
  output logic [WIDTH-1:0]         first_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Detection, all combinational on the current cycle's inputs
  logic [4:0]       ena_cnt;
  logic [3:0]       sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic [1:0]       nzp_sum;
  logic             det_multi, det_bus, det_flag, det_nzp, det_any;
  logic [2:0]       det_code;

  // Registered state
  logic             err_multi_q, err_multi_d;
  logic             err_bus_q,   err_bus_d;
  logic             err_flag_q,  err_flag_d;
  logic             err_nzp_q,   err_nzp_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             fv_q,        fv_d;
  logic [2:0]       fcode_q,     fcode_d;
  logic [3:0]       fdrv_q,      fdrv_d;
  logic [WIDTH-1:0] fdata_q,     fdata_d;
  logic             exp_valid_q, exp_valid_d;
  logic [2:0]       exp_nzp_q,   exp_nzp_d;

  always_comb begin
    ena_cnt  = '0;
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (drv_ena[i]) begin
        ena_cnt  = ena_cnt + 5'd1;
        sel_idx  = 4'(i);
        sel_data = drv_data[i*WIDTH +: WIDTH];
      end
    end

    nzp_sum   = {1'b0, n} + {1'b0, z} + {1'b0, p};
    det_multi = (ena_cnt > 5'd1);
    // With no driver enabled the bus floats, so it is left unchecked.
    det_bus   = (ena_cnt == 5'd1) && (bus != sel_data);
    det_flag  = exp_valid_q && ({n, z, p} != exp_nzp_q);
    det_nzp   = (nzp_sum > 2'd1);
    det_any   = det_multi | det_bus | det_flag | det_nzp;

    if (det_multi)     det_code = 3'd1;
    else if (det_bus)  det_code = 3'd2;
    else if (det_flag) det_code = 3'd3;
    else               det_code = 3'd4;
  end

  always_comb begin
    err_multi_d = err_multi_q | det_multi;
    err_bus_d   = err_bus_q   | det_bus;
    err_flag_d  = err_flag_q  | det_flag;
    err_nzp_d   = err_nzp_q   | det_nzp;
    cnt_d       = cnt_q;
    fv_d        = fv_q;
    fcode_d     = fcode_q;
    fdrv_d      = fdrv_q;
    fdata_d     = fdata_q;
    // Each flag_we predicts the flags for the next cycle only; a later
    // flag_we simply overwrites the prediction.
    exp_valid_d = flag_we;
    exp_nzp_d   = {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && (bus != '0)};

    if (det_any && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

    if (det_any && !fv_q) begin
      fv_d    = 1'b1;
      fcode_d = det_code;
      fdrv_d  = (det_code == 3'd2) ? sel_idx : 4'd0;
      fdata_d = bus;
    end

    // clear wins over anything detected in the same cycle.
    if (clear) begin
      err_multi_d = 1'b0;
      err_bus_d   = 1'b0;
      err_flag_d  = 1'b0;
      err_nzp_d   = 1'b0;
      cnt_d       = '0;
      fv_d        = 1'b0;
      fcode_d     = '0;
      fdrv_d      = '0;
      fdata_d     = '0;
      exp_valid_d = 1'b0;
    end
  end

  // Reset also drops any pending expectation, so the first cycle after reset
  // is never flag-checked.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi_q <= 1'b0;
      err_bus_q   <= 1'b0;
      err_flag_q  <= 1'b0;
      err_nzp_q   <= 1'b0;
      cnt_q       <= '0;
      fv_q        <= 1'b0;
      fcode_q     <= '0;
      fdrv_q      <= '0;
      fdata_q     <= '0;
      exp_valid_q <= 1'b0;
      exp_nzp_q   <= '0;
    end else begin
      err_multi_q <= err_multi_d;
      err_bus_q   <= err_bus_d;
      err_flag_q  <= err_flag_d;
      err_nzp_q   <= err_nzp_d;
      cnt_q       <= cnt_d;
      fv_q        <= fv_d;
      fcode_q     <= fcode_d;
      fdrv_q      <= fdrv_d;
      fdata_q     <= fdata_d;
      exp_valid_q <= exp_valid_d;
      exp_nzp_q   <= exp_nzp_d;
    end
  end

  assign err_multi   = err_multi_q;
  assign err_bus     = err_bus_q;
  assign err_flag    = err_flag_q;
  assign err_nzp     = err_nzp_q;
  assign err_count   = cnt_q;
  assign first_valid = fv_q;
  assign first_code  = fcode_q;
  assign first_drv   = fdrv_q;
  assign first_data  = fdata_q;

endmodule

// File: tb/tb_bus_flag_monitor.sv
module tb_bus_flag_monitor;

  localparam int W  = 16;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] drv_ena;
  logic [ND*W-1:0] drv_data;
  logic [W-1:0]  bus;
  logic          flag_we, n, z, p, clear;

  logic          err_multi, err_bus, err_flag, err_nzp;
  logic [7:0]    err_count;
  logic          first_valid;
  logic [2:0]    first_code;
  logic [3:0]    first_drv;
  logic [W-1:0]  first_data;

  logic          s_err_multi, s_err_bus, s_err_flag, s_err_nzp;
  logic [1:0]    s_err_count;
  logic          s_first_valid;
  logic [2:0]    s_first_code;
  logic [3:0]    s_first_drv;
  logic [W-1:0]  s_first_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_flag_monitor #(.WIDTH(W), .NUM_DRV(ND), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .drv_ena(drv_ena), .drv_data(drv_data), .bus(bus),
    .flag_we(flag_we), .n(n), .z(z), .p(p), .clear(clear),
    .err_multi(err_multi), .err_bus(err_bus), .err_flag(err_flag),
    .err_nzp(err_nzp), .err_count(err_count), .first_valid(first_valid),
    .first_code(first_code), .first_drv(first_drv), .first_data(first_data)
  );

  // Narrow-counter instance on the same stimulus, for saturation behaviour.
  bus_flag_monitor #(.WIDTH(W), .NUM_DRV(ND), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .drv_ena(drv_ena), .drv_data(drv_data), .bus(bus),
    .flag_we(flag_we), .n(n), .z(z), .p(p), .clear(clear),
    .err_multi(s_err_multi), .err_bus(s_err_bus), .err_flag(s_err_flag),
    .err_nzp(s_err_nzp), .err_count(s_err_count), .first_valid(s_first_valid),
    .first_code(s_first_code), .first_drv(s_first_drv), .first_data(s_first_data)
  );

  // Reference model state
  bit       m_multi, m_bus, m_flag, m_nzp;
  int       m_cnt, m_cnt2;
  bit       m_fv;
  int       m_fcode, m_fdrv;
  bit [W-1:0] m_fdata;
  bit       m_ev;
  bit [2:0] m_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_multi = 0; m_bus = 0; m_flag = 0; m_nzp = 0;
    m_cnt = 0; m_cnt2 = 0; m_fv = 0; m_fcode = 0; m_fdrv = 0; m_fdata = '0;
    m_ev = 0; m_exp = '0;
  endtask

  // Advance one clock: evaluate the rules on the current inputs, let the
  // edge happen, then compare every output of both instances.
  task automatic step();
    int ones, idx, code;
    bit e1, e2, e3, e4;
    ones = $countones(drv_ena);
    idx  = 0;
    for (int i = 0; i < ND; i++) if (drv_ena[i]) idx = i;
    e1 = (ones > 1);
    e2 = (ones == 1) && (bus != drv_data[idx*W +: W]);
    e3 = m_ev && ({n, z, p} != m_exp);
    e4 = (int'(n) + int'(z) + int'(p)) > 1;
    code = e1 ? 1 : e2 ? 2 : e3 ? 3 : 4;
    @(posedge clk);
    if (rst || clear) begin
      model_zero();
    end else begin
      if (e1 || e2 || e3 || e4) begin
        m_multi |= e1; m_bus |= e2; m_flag |= e3; m_nzp |= e4;
        m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
        m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        if (!m_fv) begin
          m_fv = 1; m_fcode = code; m_fdrv = (code == 2) ? idx : 0; m_fdata = bus;
        end
      end
      m_ev  = flag_we;
      m_exp = {bus[W-1], bus == 0, !bus[W-1] && bus != 0};
    end
    #1;
    check("err_multi",   32'(err_multi),   32'(m_multi));
    check("err_bus",     32'(err_bus),     32'(m_bus));
    check("err_flag",    32'(err_flag),    32'(m_flag));
    check("err_nzp",     32'(err_nzp),     32'(m_nzp));
    check("err_count",   32'(err_count),   32'(m_cnt));
    check("first_valid", 32'(first_valid), 32'(m_fv));
    check("first_code",  32'(first_code),  32'(m_fcode));
    check("first_drv",   32'(first_drv),   32'(m_fdrv));
    check("first_data",  32'(first_data),  32'(m_fdata));
    check("sat_count",   32'(s_err_count), 32'(m_cnt2));
    check("sat_fcode",   32'(s_first_code), 32'(m_fcode));
  endtask

  task automatic idle_inputs();
    rst = 0; clear = 0; flag_we = 0; drv_ena = '0; drv_data = '0;
    bus = '0; n = 0; z = 0; p = 0;
  endtask

  task automatic do_clear();
    idle_inputs(); clear = 1; step(); clear = 0;
  endtask

  initial begin
    model_zero();
    idle_inputs();
    rst = 1;
    repeat (3) step();
    check("rst_count", 32'(err_count), 32'd0);
    check("rst_fv",    32'(first_valid), 32'd0);

    // Single enabled driver matching the bus: no errors.
    rst = 0;
    drv_ena = 4'b0100; drv_data[2*W +: W] = 16'h1234; bus = 16'h1234;
    repeat (10) step();
    check("clean_count", 32'(err_count), 32'd0);
    check("clean_bus",   32'(err_bus),   32'd0);

    // Two drivers enabled.
    drv_ena = 4'b0101; bus = 16'h5a5a; step();
    drv_ena = 4'b0000; step();
    check("multi_flag", 32'(err_multi),  32'd1);
    check("multi_code", 32'(first_code), 32'd1);
    check("multi_data", 32'(first_data), 32'h5a5a);

    // Flag expectation from a negative bus value.
    do_clear();
    bus = 16'h8000; flag_we = 1; step();
    flag_we = 0; bus = 16'h0000; {n, z, p} = 3'b010; step();
    check("flag_err",  32'(err_flag),   32'd1);
    check("flag_code", 32'(first_code), 32'd3);
    do_clear();
    bus = 16'h8000; flag_we = 1; step();
    flag_we = 0; {n, z, p} = 3'b100; step();
    check("flag_ok", 32'(err_flag), 32'd0);

    // Bus mismatch and illegal NZP in the same cycle.
    do_clear();
    drv_ena = 4'b0010; drv_data[W +: W] = 16'h1111; bus = 16'h2222;
    {n, z, p} = 3'b110; step();
    check("both_bus",  32'(err_bus),    32'd1);
    check("both_nzp",  32'(err_nzp),    32'd1);
    check("both_code", 32'(first_code), 32'd2);
    check("both_drv",  32'(first_drv),  32'd1);
    check("both_cnt",  32'(err_count),  32'd1);

    // Saturation of the narrow counter, then clear.
    do_clear();
    drv_ena = 4'b0011;
    repeat (6) step();
    check("sat_stop", 32'(s_err_count), 32'd3);
    do_clear();
    check("clr_count", 32'(err_count), 32'd0);
    check("clr_multi", 32'(err_multi), 32'd0);

    // flag_we during reset must not produce a flag check afterwards.
    rst = 1; flag_we = 1; bus = 16'h8000; step();
    rst = 0; flag_we = 0; {n, z, p} = 3'b010; step();
    check("rst_noflag", 32'(err_flag), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int r;
      int sel;
      rst   = ($urandom_range(0, 79) == 0);
      clear = ($urandom_range(0, 49) == 0);
      drv_data = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      sel = $urandom_range(0, ND - 1);
      if (r < 2)      drv_ena = '0;
      else if (r < 8) drv_ena = ND'(1) << sel;
      else            drv_ena = ND'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)      bus = drv_data[sel*W +: W];
      else if (r == 7) bus = 16'h0000;
      else if (r == 8) bus = 16'h8000;
      else            bus = 16'($urandom);
      flag_we = $urandom_range(0, 1);
      if ($urandom_range(0, 3) != 0) {n, z, p} = m_exp;
      else                           {n, z, p} = 3'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
